// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: CH-channel PWM, shared prescaler and period counter, shadowed config loaded at the period boundary.
// Latency: pwm and period_end are registered, 1 clk behind cnt. Backpressure: none, outputs free-run while ena=1.
// Optional PWM_CENTER_EN selects center-aligned up/down counting; default build is edge-aligned sawtooth.
module pwm_multi_channel #(
  parameter int CH      = 4,
  parameter int CNT_W   = 8,
  parameter int PSC_W   = 4,
  parameter int PSC_RST = 11,
  parameter int PER_RST = 199
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [PSC_W-1:0]      psc_div,
  input  logic [CNT_W-1:0]      period,
  input  logic [CH*CNT_W-1:0]   match,
  output logic [CH-1:0]         pwm,
  output logic                  period_end,
  output logic [CNT_W-1:0]      cnt
);

  logic [PSC_W-1:0]          psc_cnt_q, psc_cnt_d;
  logic [PSC_W-1:0]          psc_div_q, psc_div_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          period_q, period_d;
  logic [CH-1:0][CNT_W-1:0]  match_q, match_d;
  logic [CH-1:0]             pwm_q, pwm_d;
  logic                      period_end_q, period_end_d;
  logic                      tick;
  logic                      boundary;
`ifdef PWM_CENTER_EN
  logic                      dir_q, dir_d;
`endif

  assign tick = ena && (psc_cnt_q == psc_div_q);

  // Period counter; boundary marks the tick where shadows reload
  always_comb begin
    cnt_d    = cnt_q;
    boundary = 1'b0;
`ifdef PWM_CENTER_EN
    dir_d    = dir_q;
    if (!ena) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (tick) begin
      if (!dir_q) begin
        if (cnt_q == period_q) begin
          if (period_q == '0) begin
            boundary = 1'b1;
          end else begin
            dir_d = 1'b1;
            cnt_d = cnt_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (cnt_q == '0) begin
        // Valley: the end value is not repeated, restart upward at 1
        boundary = 1'b1;
        dir_d    = 1'b0;
        cnt_d    = (period == '0) ? '0 : CNT_W'(1);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
`else
    if (!ena) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == period_q) begin
        boundary = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_comb begin
    psc_cnt_d    = psc_cnt_q;
    psc_div_d    = psc_div_q;
    period_d     = period_q;
    match_d      = match_q;
    pwm_d        = pwm_q;
    period_end_d = 1'b0;
    if (!ena) begin
      // Idle: shadows track the inputs so they apply the moment ena rises
      psc_cnt_d = '0;
      pwm_d     = '0;
      psc_div_d = psc_div;
      period_d  = period;
      match_d   = match;
    end else begin
      psc_cnt_d    = tick ? '0 : psc_cnt_q + 1'b1;
      period_end_d = boundary;
      if (boundary) begin
        psc_div_d = psc_div;
        period_d  = period;
        match_d   = match;
      end
      for (int i = 0; i < CH; i++) begin
        pwm_d[i] = (cnt_q < match_q[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_cnt_q    <= '0;
      psc_div_q    <= PSC_W'(PSC_RST);
      cnt_q        <= '0;
      period_q     <= CNT_W'(PER_RST);
      match_q      <= '0;
      pwm_q        <= '0;
      period_end_q <= 1'b0;
`ifdef PWM_CENTER_EN
      dir_q        <= 1'b0;
`endif
    end else begin
      psc_cnt_q    <= psc_cnt_d;
      psc_div_q    <= psc_div_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      match_q      <= match_d;
      pwm_q        <= pwm_d;
      period_end_q <= period_end_d;
`ifdef PWM_CENTER_EN
      dir_q        <= dir_d;
`endif
    end
  end

  assign pwm        = pwm_q;
  assign period_end = period_end_q;
  assign cnt        = cnt_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: reset, duty, shadow timing, extremes, ena gating, fast periods.
`timescale 1ns/1ps
module tb_pwm_multi_channel;
  localparam int CH    = 4;
  localparam int CNT_W = 8;
  localparam int PSC_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                ena;
  logic [PSC_W-1:0]    psc_div;
  logic [CNT_W-1:0]    period;
  logic [CH*CNT_W-1:0] match;
  logic [CH-1:0]       pwm;
  logic                period_end;
  logic [CNT_W-1:0]    cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_multi_channel #(
    .CH(CH), .CNT_W(CNT_W), .PSC_W(PSC_W), .PSC_RST(11), .PER_RST(199)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .psc_div(psc_div), .period(period),
    .match(match), .pwm(pwm), .period_end(period_end), .cnt(cnt)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_match(input logic [7:0] m3, input logic [7:0] m2,
                           input logic [7:0] m1, input logic [7:0] m0);
    match = {m3, m2, m1, m0};
  endtask

  task automatic wait_period_end(input int max_cyc, output bit seen, output int n);
    seen = 1'b0;
    n = 0;
    while (n < max_cyc && !seen) begin
      step();
      n++;
      if (period_end === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; psc_div = 4'd11; period = 8'd199;
    set_match(0, 0, 0, 50);
    step(); step();
    checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d expected 0", cnt); end
    checks++; if (pwm !== 4'd0) begin errors++; $display("FAIL reset_pwm got %b expected 0000", pwm); end
    checks++; if (period_end !== 1'b0) begin errors++; $display("FAIL reset_pe got %b expected 0", period_end); end
    rst = 1'b0;
    step();
    checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL idle_cnt got %0d expected 0", cnt); end
  endtask

  task automatic test_default_duty();
    bit seen; int n; int hi; int pe_n; int pe_last;
    ena = 1'b1;
    wait_period_end(3000, seen, n);
    checks++; if (!seen || n != 2400) begin errors++; $display("FAIL first_boundary got %0d expected 2400", n); end
    hi = 0; pe_n = 0; pe_last = 0;
    for (int i = 1; i <= 2400; i++) begin
      step();
      if (pwm[0] === 1'b1) hi++;
      if (period_end === 1'b1) begin pe_n++; pe_last = i; end
    end
    checks++; if (hi != 600) begin errors++; $display("FAIL duty50_high got %0d expected 600", hi); end
    checks++; if (pe_n != 1 || pe_last != 2400) begin errors++; $display("FAIL duty50_pe got %0d at %0d expected 1 at 2400", pe_n, pe_last); end
  endtask

  task automatic test_duty_change();
    int hi; int pe_last;
    hi = 0; pe_last = 0;
    for (int i = 1; i <= 2400; i++) begin
      if (i == 1000) set_match(0, 0, 0, 100);
      step();
      if (pwm[0] === 1'b1) hi++;
      if (period_end === 1'b1) pe_last = i;
    end
    checks++; if (hi != 600) begin errors++; $display("FAIL duty_hold_high got %0d expected 600", hi); end
    checks++; if (pe_last != 2400) begin errors++; $display("FAIL duty_hold_pe got %0d expected 2400", pe_last); end
    hi = 0; pe_last = 0;
    for (int i = 1; i <= 2400; i++) begin
      step();
      if (pwm[0] === 1'b1) hi++;
      if (period_end === 1'b1) pe_last = i;
    end
    checks++; if (hi != 1200) begin errors++; $display("FAIL duty100_high got %0d expected 1200", hi); end
    checks++; if (pe_last != 2400) begin errors++; $display("FAIL duty100_pe got %0d expected 2400", pe_last); end
  endtask

  task automatic test_extremes();
    bit seen; int n; int bad1; int bad2;
    set_match(0, 255, 0, 100);
    wait_period_end(2500, seen, n);
    checks++; if (!seen || n != 2400) begin errors++; $display("FAIL ext_boundary got %0d expected 2400", n); end
    bad1 = 0; bad2 = 0;
    for (int i = 1; i <= 2400; i++) begin
      step();
      if (pwm[1] !== 1'b0) bad1++;
      if (pwm[2] !== 1'b1) bad2++;
    end
    checks++; if (bad1 != 0) begin errors++; $display("FAIL match0_low got %0d bad cycles expected 0", bad1); end
    checks++; if (bad2 != 0) begin errors++; $display("FAIL match255_high got %0d bad cycles expected 0", bad2); end
  endtask

  task automatic test_ena_drop();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2500 && !found; i++) begin
      step();
      if (cnt === 8'd120) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL reach_cnt120 got %0d expected 120", cnt); end
    ena = 1'b0;
    step();
    checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL ena_off_cnt got %0d expected 0", cnt); end
    checks++; if (pwm !== 4'd0) begin errors++; $display("FAIL ena_off_pwm got %b expected 0000", pwm); end
    checks++; if (period_end !== 1'b0) begin errors++; $display("FAIL ena_off_pe got %b expected 0", period_end); end
    psc_div = 4'd0; period = 8'd3;
    set_match(0, 0, 0, 2);
    step();
    checks++; if (cnt !== 8'd0 || pwm !== 4'd0) begin errors++; $display("FAIL ena_hold got cnt %0d pwm %b expected 0 0000", cnt, pwm); end
  endtask

  task automatic test_fast_period();
    int exp_cnt[8]; int exp_pwm[8]; int exp_pe[8];
    exp_cnt = '{1, 2, 3, 0, 1, 2, 3, 0};
    exp_pwm = '{1, 1, 0, 0, 1, 1, 0, 0};
    exp_pe  = '{0, 0, 0, 1, 0, 0, 0, 1};
    ena = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (cnt !== CNT_W'(exp_cnt[i])) begin errors++; $display("FAIL fast_cnt[%0d] got %0d expected %0d", i, cnt, exp_cnt[i]); end
      checks++; if (pwm !== 4'(exp_pwm[i])) begin errors++; $display("FAIL fast_pwm[%0d] got %b expected %0d", i, pwm, exp_pwm[i]); end
      checks++; if (period_end !== 1'(exp_pe[i])) begin errors++; $display("FAIL fast_pe[%0d] got %b expected %0d", i, period_end, exp_pe[i]); end
    end
  endtask

  task automatic test_period_change();
    int exp_cnt[10]; int exp_pwm[10]; int exp_pe[10];
    exp_cnt = '{1, 2, 3, 0, 1, 2, 3, 4, 5, 0};
    exp_pwm = '{1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
    exp_pe  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    period = 8'd5;
    set_match(0, 0, 0, 4);
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (cnt !== CNT_W'(exp_cnt[i])) begin errors++; $display("FAIL per_cnt[%0d] got %0d expected %0d", i, cnt, exp_cnt[i]); end
      checks++; if (pwm[0] !== 1'(exp_pwm[i])) begin errors++; $display("FAIL per_pwm[%0d] got %b expected %0d", i, pwm[0], exp_pwm[i]); end
      checks++; if (period_end !== 1'(exp_pe[i])) begin errors++; $display("FAIL per_pe[%0d] got %b expected %0d", i, period_end, exp_pe[i]); end
    end
  endtask

  task automatic test_zero_period();
    bit seen; int n; int bad;
    period = 8'd0;
    set_match(0, 0, 0, 1);
    wait_period_end(20, seen, n);
    checks++; if (!seen || n != 6) begin errors++; $display("FAIL zero_boundary got %0d expected 6", n); end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (cnt !== 8'd0 || period_end !== 1'b1 || pwm[1:0] !== 2'b01) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL zero_period got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_reset_midrun();
    int hi; int pe_n; int pe_first; int pe_last;
    psc_div = 4'd0; period = 8'd3;
    set_match(0, 0, 0, 2);
    step(); step();
    rst = 1'b1;
    step();
    checks++; if (cnt !== 8'd0 || pwm !== 4'd0 || period_end !== 1'b0) begin errors++; $display("FAIL midrun_reset got cnt %0d pwm %b pe %b expected 0 0000 0", cnt, pwm, period_end); end
    rst = 1'b0;
    hi = 0; pe_n = 0; pe_first = 0; pe_last = 0;
    for (int i = 1; i <= 2404; i++) begin
      step();
      if (i <= 2400 && pwm[0] === 1'b1) hi++;
      if (period_end === 1'b1) begin
        pe_n++;
        if (pe_first == 0) pe_first = i;
        pe_last = i;
      end
    end
    checks++; if (hi != 0) begin errors++; $display("FAIL rst_match_default got %0d high expected 0", hi); end
    checks++; if (pe_first != 2400) begin errors++; $display("FAIL rst_period_default got %0d expected 2400", pe_first); end
    checks++; if (pe_n != 2 || pe_last != 2404) begin errors++; $display("FAIL rst_reload got %0d at %0d expected 2 at 2404", pe_n, pe_last); end
  endtask

`ifdef PWM_CENTER_EN
  task automatic test_center();
    int exp_cnt[12]; int exp_pwm[12]; int exp_pe[12];
    exp_cnt = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};
    exp_pwm = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    exp_pe  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    psc_div = 4'd0; period = 8'd3;
    set_match(0, 0, 0, 2);
    step();
    ena = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if (cnt !== CNT_W'(exp_cnt[i])) begin errors++; $display("FAIL ctr_cnt[%0d] got %0d expected %0d", i, cnt, exp_cnt[i]); end
      checks++; if (pwm[0] !== 1'(exp_pwm[i])) begin errors++; $display("FAIL ctr_pwm[%0d] got %b expected %0d", i, pwm[0], exp_pwm[i]); end
      checks++; if (period_end !== 1'(exp_pe[i])) begin errors++; $display("FAIL ctr_pe[%0d] got %b expected %0d", i, period_end, exp_pe[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PWM_CENTER_EN
    test_center();
`else
    test_default_duty();
    test_duty_change();
    test_extremes();
    test_ena_drop();
    test_fast_period();
    test_period_change();
    test_zero_period();
    test_reset_midrun();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
